// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle between the MIPS control/datapath and the multiply/divide unit.
// The master drives the request side; the slave (muldiv_seq) drives status and HI/LO.
interface muldiv_seq_if;
    logic        start;
    logic        is_mult;
    logic        is_unsigned;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, is_mult, is_unsigned, op_a, op_b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, is_mult, is_unsigned, op_a, op_b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Fixed 34-cycle issue interval: latch, 32 magnitude iterations, one sign-fix/writeback edge.
module muldiv_seq (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        mult_q, mult_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic        bzero_q, bzero_d;
    logic [31:0] a_mag_q, a_mag_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic [63:0] acc_q, acc_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    logic [31:0] a_abs, b_abs;
    logic [32:0] sum, rem_sh, diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, a_orig;

    always_comb begin
        a_abs    = (!bus.is_unsigned && bus.op_a[31]) ? -bus.op_a : bus.op_a;
        b_abs    = (!bus.is_unsigned && bus.op_b[31]) ? -bus.op_b : bus.op_b;
        sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_mag_q} : 33'd0);
        rem_sh   = {rem_q[31:0], acc_q[31]};
        diff     = rem_sh - {1'b0, b_mag_q};
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[31:0] : acc_q[31:0];
        rem_fix  = neg_a_q ? -rem_q[31:0] : rem_q[31:0];
        // Re-negating the magnitude recovers the dividend exactly, 0x80000000 included.
        a_orig   = neg_a_q ? -a_mag_q : a_mag_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        mult_d  = mult_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        bzero_d = bzero_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mult_d  = bus.is_mult;
                    neg_a_d = !bus.is_unsigned && bus.op_a[31];
                    neg_b_d = !bus.is_unsigned && bus.op_b[31];
                    bzero_d = (bus.op_b == 32'd0);
                    a_mag_d = a_abs;
                    b_mag_d = b_abs;
                    acc_d   = {32'd0, bus.is_mult ? b_abs : a_abs};
                    rem_d   = 33'd0;
                    cnt_d   = 6'd0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (mult_q) begin
                    acc_d = {sum, acc_q[31:1]};
                end else if (!diff[32]) begin
                    rem_d = diff;
                    acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (mult_q) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (bzero_q) begin
                    hi_d = a_orig;
                    lo_d = 32'hFFFF_FFFF;
                    dz_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            mult_q  <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            bzero_q <= 1'b0;
            a_mag_q <= 32'd0;
            b_mag_q <= 32'd0;
            acc_q   <= 64'd0;
            rem_q   <= 33'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mult_q  <= mult_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            bzero_q <= bzero_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
